pulse_channel: RTL
==================

# pulse_channel

Parametrised square-wave channel for the APU, successor to the single-channel pulse generator. Runs entirely on `apu_clk`, with quarter- and half-frame events arriving as one-cycle enables rather than separate clocks. Registers are loaded through a byte-wide write port, so each write triggers only the side effects that belong to it; no whole-register change detection is used. Adds sweep muting, ones/twos-complement negate selection, and a channel-enable gate; one instance per pulse voice sits beside the frame sequencer.

## Interface
- `TIMER_W`, 11: timer/period width, legal 8..11; period = {reg3[TIMER_W-9:0], reg2}.
- `VOL_W`, 4: envelope/volume width.
- `NEG_ONES`, 0: 1 = ones-complement sweep negate (voice 1); 0 = twos-complement (voice 2).
- `apu_clk`  in  1  channel clock; the timer decrements once per cycle.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `qtr_tick`  in  1  quarter-frame enable, one cycle wide.
- `hlf_tick`  in  1  half-frame enable; always coincident with a `qtr_tick`.
- `wr_en`  in  1  register write strobe.
- `wr_addr`  in  2  register select 0..3.
- `wr_data`  in  8  write data.
- `chan_en`  in  1  channel enable; low forces the length counter to 0 and blocks length loads.
- `pulse_out`  out  VOL_W+1  signed sample, registered.
- `active`  out  1  high when the length counter is nonzero.

## Operation
- Reg 0 fields: [7:6] duty, [5] halt/loop, [4] constant volume, [3:0] volume/envelope period.
- Reg 1 fields: [7] sweep enable, [6:4] sweep period P, [3] negate, [2:0] shift.
- Reg 2 fields: period low byte.
- Reg 3 fields: [7:3] length index, [2:0] period high bits.
- Write side effects:
  - Reg 1: sets `swp_reload`.
  - Reg 3: loads the length counter (only if `chan_en`), sets `env_start`, and clears the sequencer index to 0. The timer counter is not touched.
- Length table, indices 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Timer:
  - When the counter is nonzero, it decrements each cycle.
  - When it is 0, it reloads the period and the sequencer index decrements mod 8 (0→7).
- Duty patterns (bit [index] = high):
  - 0: 8'b00000010
  - 1: 8'b00000110
  - 2: 8'b00011110
  - 3: 8'b11111001
- Envelope, on `qtr_tick`:
  - If `env_start`: clear it, set decay to all-ones, set divider to the envelope period.
  - Otherwise, when divider = 0: reload the divider; decay decrements if nonzero, else wraps to all-ones when halt is set.
  - Otherwise: divider decrements.
- Volume = constant-volume flag ? reg0[3:0] : decay.
- Length, on `hlf_tick`: decrements if nonzero and halt is clear.
  - A reg-3 write in the same cycle wins over the decrement.
  - `chan_en` low wins over everything.
- Sweep, on `hlf_tick`:
  - change = period >> shift.
  - target = negate ? period − change − NEG_ONES : period + change, computed TIMER_W+1 bits wide.
  - If divider = 0, enable, shift ≠ 0 and not muted: period ← target (overwrites the reg 2/3 fields).
  - If divider = 0 or `swp_reload`: divider ← P and `swp_reload` clears; otherwise divider decrements.
- Mute when period < 8, or when target exceeds 2^TIMER_W − 1 with negate clear. Mute is evaluated every cycle, independent of sweep enable.
- Output, every cycle:
  - `pulse_out` ← 0 if muted or length = 0.
  - Else +volume if the duty bit is set, −volume if clear.

## Timing
- Reset values: `pulse_out` = 0; `active` = 0.
- Reset values, internal state: all registers, counters, sequencer index, decay and dividers = 0; start and reload flags = 0.
- A write in cycle N is visible to the datapath at N+1; its flags are consumed by the next tick.
- `pulse_out` lags the sequencer/mute state by one cycle. `active` is combinational from the length counter.
- Write coincident with `hlf_tick`: the register update and the tick both act on pre-write state, except the length load, which wins.
- Reset asserted mid-operation returns all state to reset values immediately. The first write after release behaves as from power-up.

## Configuration
- `PULSE_SWEEP_EN` defined: sweep unit and sweep-overflow mute are present as above.
- Undefined: no sweep logic is built. Reg 1 writes are ignored, the period comes only from regs 2/3, and mute is period < 8 only.

## Test plan
- Reg0 = 0xBF, reg2 = 0x08, reg3 = 0x08 -> `pulse_out` toggles +15/−15 per duty 2; each sequencer step is 9 cycles; `active` = 1.
- Reg0 = 0x00, reg3 = 0x18 (index 3, length 2), two `hlf_tick` -> `active` falls after the second tick; `pulse_out` = 0.
- Reg0 = 0x03, reg3 write, then 4×4 `qtr_tick` -> decay steps 15→14→13→12.
- Reg1 = 0x81, period 0x600, with sweep enabled -> target = 0x900 overflow; output muted at 0 and period unchanged after `hlf_tick`.
- Reg1 = 0x89, period 0x100, NEG_ONES = 1 -> after P+1 half-frames the period = 0x100 − 0x80 − 1 = 0x7F.
- `rst_n` pulsed low during playback -> `pulse_out` = 0 asynchronously, `active` = 0; no output until reg 3 is rewritten.

Source files
------------

// File: rtl/pulse_channel.sv
// pulse_channel: square-wave APU voice with duty sequencer, envelope, length counter.
// Define PULSE_SWEEP_EN to build the sweep unit and its overflow mute.
module pulse_channel #(
  parameter int TIMER_W  = 11,
  parameter int VOL_W    = 4,
  parameter bit NEG_ONES = 1'b0
) (
  input  logic                    apu_clk,
  input  logic                    rst_n,
  input  logic                    qtr_tick,
  input  logic                    hlf_tick,
  input  logic                    wr_en,
  input  logic [1:0]              wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    chan_en,
  output logic signed [VOL_W:0]   pulse_out,
  output logic                    active
);

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    logic [7:0] len;
    case (idx)
      5'd0:    len = 8'd10;
      5'd1:    len = 8'd254;
      5'd2:    len = 8'd20;
      5'd3:    len = 8'd2;
      5'd4:    len = 8'd40;
      5'd5:    len = 8'd4;
      5'd6:    len = 8'd80;
      5'd7:    len = 8'd6;
      5'd8:    len = 8'd160;
      5'd9:    len = 8'd8;
      5'd10:   len = 8'd60;
      5'd11:   len = 8'd10;
      5'd12:   len = 8'd14;
      5'd13:   len = 8'd12;
      5'd14:   len = 8'd26;
      5'd15:   len = 8'd14;
      5'd16:   len = 8'd12;
      5'd17:   len = 8'd16;
      5'd18:   len = 8'd24;
      5'd19:   len = 8'd18;
      5'd20:   len = 8'd48;
      5'd21:   len = 8'd20;
      5'd22:   len = 8'd96;
      5'd23:   len = 8'd22;
      5'd24:   len = 8'd192;
      5'd25:   len = 8'd24;
      5'd26:   len = 8'd72;
      5'd27:   len = 8'd26;
      5'd28:   len = 8'd16;
      5'd29:   len = 8'd28;
      5'd30:   len = 8'd32;
      default: len = 8'd30;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] duty_pattern(input logic [1:0] sel);
    logic [7:0] pat;
    case (sel)
      2'd0:    pat = 8'b0000_0010;
      2'd1:    pat = 8'b0000_0110;
      2'd2:    pat = 8'b0001_1110;
      default: pat = 8'b1111_1001;
    endcase
    return pat;
  endfunction

  logic               wr0, wr2, wr3;
  logic [7:0]         reg0;
  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         seq_idx;
  logic [7:0]         length;
  logic               env_start;
  logic [3:0]         env_div;
  logic [VOL_W-1:0]   decay;
  logic [VOL_W-1:0]   volume;
  logic [7:0]         pattern;
  logic               duty_bit;
  logic               mute;
  logic [10:0]        hi_merge;
  logic signed [VOL_W:0] vol_signed;

  assign wr0 = wr_en && (wr_addr == 2'd0);
  assign wr2 = wr_en && (wr_addr == 2'd2);
  assign wr3 = wr_en && (wr_addr == 2'd3);

  // A reg-3 write replaces only the high period bits and keeps the live low byte.
  assign hi_merge = {wr_data[2:0], period[7:0]};

`ifdef PULSE_SWEEP_EN
  logic               wr1;
  logic [7:0]         reg1;
  logic [2:0]         swp_div;
  logic               swp_reload;
  logic [TIMER_W:0]   period_x;
  logic [TIMER_W:0]   change;
  logic [TIMER_W:0]   target;
  logic               swp_mute;

  assign wr1      = wr_en && (wr_addr == 2'd1);
  assign period_x = {1'b0, period};
  assign change   = period_x >> reg1[2:0];
  assign target   = reg1[3] ? (period_x - change - {{TIMER_W{1'b0}}, NEG_ONES})
                            : (period_x + change);
  assign swp_mute = !reg1[3] && target[TIMER_W];
  assign mute     = (period[TIMER_W-1:3] == '0) || swp_mute;
`else
  assign mute     = (period[TIMER_W-1:3] == '0);
`endif

  // Register file; a same-cycle write overrides any sweep update of the period.
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg0   <= '0;
      period <= '0;
`ifdef PULSE_SWEEP_EN
      reg1       <= '0;
      swp_div    <= '0;
      swp_reload <= 1'b0;
`endif
    end else begin
`ifdef PULSE_SWEEP_EN
      if (hlf_tick) begin
        if ((swp_div == 3'd0) && reg1[7] && (reg1[2:0] != 3'd0) && !mute)
          period <= target[TIMER_W-1:0];
        if ((swp_div == 3'd0) || swp_reload) begin
          swp_div    <= reg1[6:4];
          swp_reload <= 1'b0;
        end else begin
          swp_div <= swp_div - 3'd1;
        end
      end
      if (wr1) begin
        reg1       <= wr_data;
        swp_reload <= 1'b1;
      end
`endif
      if (wr0) reg0 <= wr_data;
      if (wr2) period[7:0] <= wr_data;
      if (wr3) period <= hi_merge[TIMER_W-1:0];
    end
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      seq_idx <= '0;
    end else begin
      if (timer != '0) begin
        timer <= timer - TIMER_W'(1);
      end else begin
        timer   <= period;
        seq_idx <= seq_idx - 3'd1;
      end
      if (wr3) seq_idx <= '0;
    end
  end

  // Envelope; a start request raised in the same cycle survives to the next tick.
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      env_start <= 1'b0;
      env_div   <= '0;
      decay     <= '0;
    end else begin
      if (qtr_tick) begin
        if (env_start) begin
          env_start <= 1'b0;
          decay     <= '1;
          env_div   <= reg0[3:0];
        end else if (env_div == 4'd0) begin
          env_div <= reg0[3:0];
          if (decay != '0) decay <= decay - VOL_W'(1);
          else if (reg0[5]) decay <= '1;
        end else begin
          env_div <= env_div - 4'd1;
        end
      end
      if (wr3) env_start <= 1'b1;
    end
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      length <= '0;
    end else if (!chan_en) begin
      length <= '0;
    end else if (wr3) begin
      length <= length_lookup(wr_data[7:3]);
    end else if (hlf_tick && (length != 8'd0) && !reg0[5]) begin
      length <= length - 8'd1;
    end
  end

  assign volume     = reg0[4] ? VOL_W'(reg0[3:0]) : decay;
  assign vol_signed = $signed({1'b0, volume});
  assign pattern    = duty_pattern(reg0[7:6]);
  assign duty_bit   = pattern[seq_idx];
  assign active     = (length != 8'd0);

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out <= '0;
    end else if (mute || (length == 8'd0)) begin
      pulse_out <= '0;
    end else if (duty_bit) begin
      pulse_out <= vol_signed;
    end else begin
      pulse_out <= -vol_signed;
    end
  end

endmodule
